key_schedule_seq: RTL and testbench
===================================

Name: key_schedule_seq

Overview:
- Iterative AES-128 round-key sequencer. Directly upstream consumer of the g-function: it feeds the function its last word, round index and direction, and turns the result into full 128-bit round keys.
- Loads a 128-bit key and streams 11 round keys, one per accepted handshake, to the cipher datapath.
- Forward mode: expands from the cipher key, key 0 to key 10.
- Inverse mode: rewinds from the final round key, key 10 down to key 0, so decryption needs no key storage.

Parameters:
- NR, 10, number of generated round keys after the initial key. Only 10 (AES-128) is supported.

Ports:
- i_Clk  input  1  clock; all state changes on its rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Start  input  1  load request; sampled only in IDLE
- i_Key  input  128  cipher key (forward) or round-10 key (inverse); word w0 = [127:96]
- i_fDec  input  1  0 = forward expansion, 1 = inverse expansion; latched on accepted start
- i_Ready  input  1  downstream accepts o_RoundKey this cycle
- o_RoundKey  output  128  current round key, registered
- o_Round  output  4  step index of o_RoundKey, 0..10
- o_Valid  output  1  o_RoundKey/o_Round valid
- o_Busy  output  1  sequence in progress (EMIT state)
- o_Done  output  1  one-cycle pulse after last key is accepted

Behaviour:
- Reset (i_Rst=1 at a clock edge, any state, including mid-sequence):
  - State goes to IDLE.
  - o_RoundKey=0, o_Round=0, o_Valid=0, o_Busy=0, o_Done=0.
  - Latched direction clears to 0.
- States:
  - IDLE: i_Start=1 -> EMIT. Register i_Key into o_RoundKey, o_Round=0, latch i_fDec. o_Valid=1 and o_Busy=1 from the next cycle (latency 1).
  - EMIT, o_Valid=1, handshake is o_Valid & i_Ready:
    - No handshake: hold o_RoundKey and o_Round stable.
    - Handshake with o_Round<10: load the next key, o_Round+1, o_Valid stays 1. Throughput is 1 key/cycle while i_Ready is held high.
    - Handshake with o_Round==10: -> DONE. o_Valid=0, o_Busy=0.
  - DONE: o_Done=1 for exactly one cycle, then IDLE.
- i_Start is ignored in EMIT and DONE. i_Key and i_fDec changes after start have no effect.
- i_Start in the DONE cycle is ignored; it is accepted on the following IDLE cycle.
- Single g-function instance, combinational, fed:
  - Word = w3 of the forward result (see below).
  - Round = o_Round (0..9).
  - Dec = latched direction.
- The g-function computes RotWord, then SubWord, then XORs the Rcon byte into bits [31:24]:
  - Forward Rcon by round 0..9: 01,02,04,08,10,20,40,80,1b,36.
  - Inverse Rcon by round 0..9: 36,1b,80,40,20,10,08,04,02,01.
- Forward next key, from o_RoundKey = {w0,w1,w2,w3}:
  - n0 = w0 ^ g(w3)
  - n1 = n0 ^ w1
  - n2 = n1 ^ w2
  - n3 = n2 ^ w3
- Inverse previous key, from o_RoundKey = {w4,w5,w6,w7}:
  - p3 = w7 ^ w6
  - p2 = w6 ^ w5
  - p1 = w5 ^ w4
  - p0 = w4 ^ g(p3)
  - g is driven with p3 in inverse mode.
- o_Round counts 0..10 in both modes. In inverse mode, step k carries true schedule key 10-k.
- Whole sequence: 11 handshakes. With i_Ready tied high: start at cycle t -> keys on cycles t+1..t+11, o_Done at t+12, new start accepted from t+13.
- All outputs registered. No combinational path from i_Ready to any output.

Test Plan:
- Forward FIPS-197, i_Key=2b7e151628aed2a6abf7158809cf4f3c, i_fDec=0, i_Ready=1:
  - o_Round=0 key equals i_Key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - o_Done one cycle after round 10.
- Inverse, i_Key=d014f9a8c9ee2589e13f0cc8b6630ca6, i_fDec=1:
  - Step 1 = ac7766f319fadc2128d12941575c006e (schedule key 9).
  - Step 10 = 2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: i_Ready random 30% duty -> key/round stable while stalled; sequence identical to the forward vectors; exactly 11 handshakes.
- Start while busy: pulse i_Start with a different key at o_Round=4 -> ignored, original sequence completes unchanged.
- Reset mid-sequence: assert i_Rst at o_Round=6 -> next cycle all outputs 0, IDLE; a fresh start then yields the correct round 0/1 keys.
- Back-to-back: start pulsed on the DONE cycle is ignored; start on the next cycle accepted, with o_Valid rising one cycle later.

Source files
------------

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: iterative AES-128 round-key sequencer.
// Streams keys 0..10 forward, or rewinds 10..0 from the last round key.
module key_schedule_seq #(
  parameter int NR = 10
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Start,
  input  logic [127:0] i_Key,
  input  logic         i_fDec,
  input  logic         i_Ready,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_Round,
  output logic         o_Valid,
  output logic         o_Busy,
  output logic         o_Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Inverse Rcon is the forward table read backwards
  function automatic logic [7:0] rcon(
    input logic [3:0] r,
    input logic       dec
  );
    logic [3:0] idx;
    logic [7:0] f;
    idx = dec ? (4'd9 - r) : r;
    case (idx)
      4'd0:    f = 8'h01;
      4'd1:    f = 8'h02;
      4'd2:    f = 8'h04;
      4'd3:    f = 8'h08;
      4'd4:    f = 8'h10;
      4'd5:    f = 8'h20;
      4'd6:    f = 8'h40;
      4'd7:    f = 8'h80;
      4'd8:    f = 8'h1b;
      4'd9:    f = 8'h36;
      default: f = 8'h00;
    endcase
    return f;
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic           dec_q, dec_d;

  logic [31:0]    k0, k1, k2, k3;
  logic [31:0]    p1, p2, p3;
  logic [31:0]    g_in, g_rot, g_out;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  always_comb begin
    k0 = key_q[127:96];
    k1 = key_q[95:64];
    k2 = key_q[63:32];
    k3 = key_q[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    g_in  = dec_q ? p3 : k3;
    g_rot = {g_in[23:0], g_in[31:24]};
    g_out = {sbox(g_rot[31:24]) ^ rcon(round_q, dec_q),
             sbox(g_rot[23:16]),
             sbox(g_rot[15:8]),
             sbox(g_rot[7:0])};
    n0 = k0 ^ g_out;
    n1 = n0 ^ k1;
    n2 = n1 ^ k2;
    n3 = n2 ^ k3;
    next_key = dec_q ? {k0 ^ g_out, p1, p2, p3}
                     : {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    dec_d   = dec_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d = S_EMIT;
          key_d   = i_Key;
          round_d = 4'd0;
          dec_d   = i_fDec;
        end
      end
      S_EMIT: begin
        if (i_Ready) begin
          if (round_q == LAST) begin
            state_d = S_DONE;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      dec_q   <= dec_d;
    end
  end

  assign o_RoundKey = key_q;
  assign o_Round    = round_q;
  assign o_Valid    = (state_q == S_EMIT);
  assign o_Busy     = (state_q == S_EMIT);
  assign o_Done     = (state_q == S_DONE);

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: word-level AES key expansion model
// compared against the sequencer every cycle, plus FIPS-197 literals.
module tb_key_schedule_seq;

  localparam logic [127:0] K_FWD  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         i_Clk = 1'b0;
  logic         i_Rst = 1'b1;
  logic         i_Start = 1'b0;
  logic [127:0] i_Key = '0;
  logic         i_fDec = 1'b0;
  logic         i_Ready = 1'b1;
  logic [127:0] o_RoundKey;
  logic [3:0]   o_Round;
  logic         o_Valid;
  logic         o_Busy;
  logic         o_Done;

  key_schedule_seq #(.NR(10)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Start    (i_Start),
    .i_Key      (i_Key),
    .i_fDec     (i_fDec),
    .i_Ready    (i_Ready),
    .o_RoundKey (o_RoundKey),
    .o_Round    (o_Round),
    .o_Valid    (o_Valid),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // GF(2^8) arithmetic for an independent S-box
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] tfun(input logic [31:0] w, input int i);
    logic [31:0] r;
    logic [7:0]  rc = 8'h01;
    if (i % 4 != 0) return w;
    r = {w[23:0], w[31:24]};
    r = {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    for (int j = 1; j < i / 4; j++) rc = xt(rc);
    return r ^ {rc, 24'h0};
  endfunction

  // Model: the 44-word schedule and the protocol position
  logic [31:0] m_w [44];
  int          m_phase = 0;
  int          m_step = 0;
  logic        m_dec = 1'b0;
  logic        m_zero = 1'b0;
  logic        m_init = 1'b0;

  task automatic expand_fwd(input logic [127:0] k);
    {m_w[0], m_w[1], m_w[2], m_w[3]} = k;
    for (int i = 4; i < 44; i++) m_w[i] = m_w[i-4] ^ tfun(m_w[i-1], i);
  endtask

  task automatic expand_inv(input logic [127:0] k);
    {m_w[40], m_w[41], m_w[42], m_w[43]} = k;
    for (int i = 43; i >= 4; i--) m_w[i-4] = m_w[i] ^ tfun(m_w[i-1], i);
  endtask

  function automatic logic [127:0] m_key(input int k);
    return {m_w[4*k], m_w[4*k+1], m_w[4*k+2], m_w[4*k+3]};
  endfunction

  always @(posedge i_Clk) begin
    if (i_Rst) begin
      m_phase = 0;
      m_step  = 0;
      m_dec   = 1'b0;
      m_zero  = 1'b1;
      m_init  = 1'b1;
    end else if (m_init) begin
      case (m_phase)
        0: if (i_Start) begin
          m_dec   = i_fDec;
          m_step  = 0;
          m_zero  = 1'b0;
          m_phase = 1;
          if (i_fDec) expand_inv(i_Key);
          else expand_fwd(i_Key);
        end
        1: if (i_Ready) begin
          if (m_step == 10) m_phase = 2;
          else m_step++;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare and handshake capture
  logic [127:0] cap [11];
  int           hs = 0;

  always @(negedge i_Clk) begin
    if (m_init) begin
      chk("valid", 128'(o_Valid), 128'(m_phase == 1));
      chk("busy", 128'(o_Busy), 128'(m_phase == 1));
      chk("done", 128'(o_Done), 128'(m_phase == 2));
      if (m_phase == 1) begin
        chk("round", 128'(o_Round), 128'(m_step));
        chk("key", o_RoundKey, m_key(m_dec ? 10 - m_step : m_step));
      end else if (m_zero) begin
        chk("rst_round", 128'(o_Round), 128'h0);
        chk("rst_key", o_RoundKey, 128'h0);
      end
      if (o_Valid && i_Ready) begin
        if (o_Round <= 4'd10) cap[o_Round] = o_RoundKey;
        hs++;
      end
    end
  end

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic pulse_start(input logic [127:0] k, input logic dec);
    hs = 0;
    for (int i = 0; i < 11; i++) cap[i] = '0;
    i_Key   = k;
    i_fDec  = dec;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    i_Key   = K_ALT;
    i_fDec  = ~dec;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!o_Done && n < 1000) begin
      step();
      n++;
    end
    if (!o_Done) chk({name, "_timeout"}, 128'(n), 128'(0));
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (!(o_Valid && o_Round == r) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("round_timeout", 128'(o_Round), 128'(r));
  endtask

  int n;

  initial begin
    build_sbox();
    chk("sbox_00", 128'(sb[0]), 128'h63);
    chk("sbox_53", 128'(sb[8'h53]), 128'hed);
    repeat (3) step();
    i_Rst = 1'b0;
    step();

    // Forward FIPS-197 with ready held high
    i_Ready = 1'b1;
    pulse_start(K_FWD, 1'b0);
    chk("model_r1", m_key(1), K_R1);
    chk("model_r10", m_key(10), K_R10);
    wait_done("fwd", n);
    chk("fwd_latency", 128'(n), 128'(11));
    chk("fwd_k0", cap[0], K_FWD);
    chk("fwd_k1", cap[1], K_R1);
    chk("fwd_k10", cap[10], K_R10);
    chk("fwd_hs", 128'(hs), 128'(11));
    step();

    // Inverse from the round-10 key
    pulse_start(K_R10, 1'b1);
    chk("model_inv9", m_key(9), K_R9);
    chk("model_inv0", m_key(0), K_FWD);
    wait_done("inv", n);
    chk("inv_s1", cap[1], K_R9);
    chk("inv_s10", cap[10], K_FWD);
    step();

    // Backpressure at roughly 30% ready
    i_Ready = 1'b0;
    pulse_start(K_FWD, 1'b0);
    n = 0;
    while (!o_Done && n < 1000) begin
      i_Ready = ($urandom_range(0, 99) < 30);
      step();
      n++;
    end
    if (!o_Done) chk("bp_timeout", 128'(n), 128'(0));
    chk("bp_hs", 128'(hs), 128'(11));
    chk("bp_k1", cap[1], K_R1);
    chk("bp_k10", cap[10], K_R10);
    i_Ready = 1'b1;
    step();

    // Start while busy is ignored
    pulse_start(K_FWD, 1'b0);
    wait_round(4'd4);
    i_Key   = K_ALT;
    i_Start = 1'b1;
    step();
    i_Start = 1'b0;
    wait_done("busy", n);
    chk("busy_k10", cap[10], K_R10);
    chk("busy_hs", 128'(hs), 128'(11));
    step();

    // Reset mid-sequence
    pulse_start(K_FWD, 1'b0);
    wait_round(4'd6);
    i_Rst = 1'b1;
    step();
    i_Rst = 1'b0;
    chk("mrst_valid", 128'(o_Valid), 128'h0);
    chk("mrst_round", 128'(o_Round), 128'h0);
    chk("mrst_key", o_RoundKey, 128'h0);
    pulse_start(K_FWD, 1'b0);
    chk("mrst_k0", o_RoundKey, K_FWD);
    step();
    chk("mrst_k1", o_RoundKey, K_R1);
    wait_done("mrst", n);

    // Start during DONE ignored, accepted on the following cycle
    i_Key   = K_FWD;
    i_fDec  = 1'b0;
    i_Start = 1'b1;
    step();
    chk("b2b_ignored", 128'(o_Valid), 128'h0);
    step();
    i_Start = 1'b0;
    chk("b2b_valid", 128'(o_Valid), 128'h1);
    chk("b2b_k0", o_RoundKey, K_FWD);
    wait_done("b2b", n);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
